ysyx_lsu_axi_bridge: RTL and testbench
======================================

// Module: ysyx_lsu_axi_bridge
// PURPOSE
//  Responder end of lsu_bus (lsu_bus_if.slave); the LSU is the initiator. Converts LSU
//  load and store requests into single-beat AXI4 transactions on one master port toward
//  the SoC crossbar. One transaction is outstanding at a time; read and write are arbitrated.
// PARAMETERS
//  XLEN         32  data/address width (lsu_bus and AXI)
//  WRITE_FIRST  1   1: a write pending with a read in IDLE wins; 0: the read wins
// PORTS
//  clock         in   1    clock
//  reset         in   1    reset, synchronous, active-high
//  lsu_arvalid   in   1    load request; held high until rvalid or until the LSU drops it on a flush
//  lsu_araddr    in   XLEN byte address; may be unaligned within the word
//  lsu_rstrb     in   8    0x01/0x03/0x0f = byte/half/word
//  lsu_rvalid    out  1    1-cycle pulse; lsu_rdata is valid in the same cycle
//  lsu_rdata     out  XLEN full aligned AXI word, not shifted (the LSU shifts by araddr[1:0])
//  lsu_awvalid   in   1    store request; always driven together with wvalid
//  lsu_awaddr    in   XLEN store byte address
//  lsu_wstrb     in   8    unshifted strobe: [3:0]=0x1/0x3/0xf, [7:4]=0
//  lsu_wvalid    in   1    store data valid
//  lsu_wdata     in   XLEN store data in the low bytes, unshifted
//  lsu_wready    out  1    1-cycle pulse; the store is globally complete (B response received)
//  bus_err       out  1    1-cycle pulse with rvalid/wready when RRESP/BRESP != OKAY
//  axi_ar*/r*/aw*/w*/b*    AXI4 master: addr XLEN, data XLEN, strb 4, size 3, len 8 (=0), burst 2 (=INCR), resp 2
// BEHAVIOUR
//  Reset: FSM=IDLE; lsu_rvalid, lsu_wready, bus_err, axi_arvalid, axi_awvalid, axi_wvalid = 0;
//    axi_rready = axi_bready = 0; abandon flag = 0.
//  FSM: IDLE -> RD_A -> RD_D -> RD_ACK -> IDLE;  IDLE -> WR_AW -> WR_B -> WR_ACK -> IDLE.
//  IDLE: sample lsu_arvalid and (lsu_awvalid&lsu_wvalid); arbitrate by WRITE_FIRST and latch
//    addr/strb/data into request registers. Inputs are not used again after the latch.
//  RD_A: axi_arvalid=1, araddr=latched addr (unmodified), arsize=0/1/2 for rstrb 1/3/f.
//    Leave on arready.
//  RD_D: rready=1. On rvalid, capture rdata/rresp.
//  RD_ACK: pulse lsu_rvalid for one cycle, unless abandoned.
//  Abandon: lsu_arvalid low in any cycle of RD_A/RD_D sets the flag. The AXI read still
//    completes (no AXI cancel). RD_ACK then emits no rvalid and no bus_err; flag clears in IDLE.
//    A new arvalid arriving in that window waits for IDLE and is treated as a fresh request.
//  WR_AW: axi_awvalid and axi_wvalid are both asserted. Each deasserts independently when its
//    handshake completes (aw_done/w_done flags); both may complete in the same cycle.
//    Leave when both are done.
//    awaddr=latched addr; sh=addr[1:0]; axi_wstrb=wstrb[3:0]<<sh; axi_wdata=wdata<<(8*sh);
//    awsize=0/1/2 for strb 1/3/f. A strobe shifted past bit 3 is truncated; the LSU guarantees alignment.
//  WR_B: bready=1; on bvalid capture bresp.
//  WR_ACK: pulse lsu_wready for one cycle; the LSU holds awvalid low the following cycle.
//  Latency: the rvalid/wready pulse comes 1 cycle after the final AXI handshake;
//    minimum request-to-pulse = 4 cycles.
//  rdata holds its last value between pulses. Outputs are registered; no comb path lsu_* -> axi_*.
//  AXI rule: valid, once raised, stays high with stable payload until ready (also under LSU flush).
//  reset mid-transaction: everything returns to IDLE at once. The SoC side is reset together, so
//    no dangling AXI transaction is tracked.
//  Simultaneous read+write in IDLE: the loser stays pending on the LSU side and is served next.
// STRUCTURE
//  ysyx_pkg: typedef enum lsu_br_state_t {IDLE,RD_A,RD_D,RD_ACK,WR_AW,WR_B,WR_ACK};
//    AXI_RESP_OKAY=2'b00; function strb2size(logic[3:0]) -> logic[2:0].
//  Sub-module ysyx_axi_lane_shift: a combinational strobe/data lane shifter, reused by the
//    future uncached-fetch path.
// TESTING
//  1. LW 0x80000004, AXI rdata=0xdeadbeef, arready at +2 -> arsize=2, araddr=0x80000004;
//     lsu_rvalid one pulse, lsu_rdata=0xdeadbeef.
//  2. SB addr 0x10000003, wdata=0x41, wstrb=0x01 -> axi_wstrb=0x8, axi_wdata=0x41000000,
//     awsize=0; wready one pulse only after bvalid.
//  3. arvalid and awvalid in the same IDLE cycle, WRITE_FIRST=1 -> write on AXI first; read
//     issued after the wready pulse; both answered exactly once.
//  4. arvalid dropped during RD_D, new LH 0x80000010 issued -> first read completes with no
//     rvalid; the second returns its own data with a single pulse.
//  5. AXI awready before wready, then wready 3 cycles later; BRESP=SLVERR -> one AW and one W
//     handshake; wready and bus_err pulse together.
//  6. reset asserted in WR_B -> next cycle: all valids 0, FSM IDLE, no wready pulse.

Source files
------------

// File: rtl/ysyx_pkg.sv
// Shared types and helpers for the LSU-to-AXI bridge and related bus logic.
package ysyx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_A   = 3'd1,
    RD_D   = 3'd2,
    RD_ACK = 3'd3,
    WR_AW  = 3'd4,
    WR_B   = 3'd5,
    WR_ACK = 3'd6
  } lsu_br_state_t;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Map an unshifted byte strobe (byte/half/word) to the AXI transfer size code.
  function automatic logic [2:0] strb2size(input logic [3:0] strb);
    logic [2:0] size;
    case (strb)
      4'h1:    size = 3'd0;
      4'h3:    size = 3'd1;
      4'hf:    size = 3'd2;
      default: size = 3'd2;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/ysyx_axi_lane_shift.sv
// Combinational byte-lane shifter: moves an unshifted strobe/data pair into the
// AXI byte lanes selected by the low address bits. Strobe bits pushed past lane 3
// are dropped; callers guarantee naturally aligned accesses.
module ysyx_axi_lane_shift #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_sh,
  input  logic [3:0]      i_strb,
  input  logic [XLEN-1:0] i_data,
  output logic [3:0]      o_strb,
  output logic [XLEN-1:0] o_data
);

  // Shift strobe by whole lanes and data by eight bits per lane.
  always_comb begin
    o_strb = i_strb << i_sh;
    o_data = i_data << {i_sh, 3'b000};
  end

endmodule

// File: rtl/ysyx_lsu_axi_bridge.sv
// LSU bus responder that turns each load/store request into a single-beat AXI4
// transaction. One transaction is in flight at a time; loads and stores are
// arbitrated in IDLE and the request is latched so the LSU inputs are not
// looked at again until the answer pulse.
module ysyx_lsu_axi_bridge
  import ysyx_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  // LSU side
  input  logic            lsu_arvalid,
  input  logic [XLEN-1:0] lsu_araddr,
  input  logic [7:0]      lsu_rstrb,
  output logic            lsu_rvalid,
  output logic [XLEN-1:0] lsu_rdata,
  input  logic            lsu_awvalid,
  input  logic [XLEN-1:0] lsu_awaddr,
  input  logic [7:0]      lsu_wstrb,
  input  logic            lsu_wvalid,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_wready,
  output logic            bus_err,
  // AXI4 master: read address / data
  output logic            axi_arvalid,
  input  logic            axi_arready,
  output logic [XLEN-1:0] axi_araddr,
  output logic [2:0]      axi_arsize,
  output logic [7:0]      axi_arlen,
  output logic [1:0]      axi_arburst,
  input  logic            axi_rvalid,
  output logic            axi_rready,
  input  logic [XLEN-1:0] axi_rdata,
  input  logic [1:0]      axi_rresp,
  // AXI4 master: write address / data / response
  output logic            axi_awvalid,
  input  logic            axi_awready,
  output logic [XLEN-1:0] axi_awaddr,
  output logic [2:0]      axi_awsize,
  output logic [7:0]      axi_awlen,
  output logic [1:0]      axi_awburst,
  output logic            axi_wvalid,
  input  logic            axi_wready,
  output logic [XLEN-1:0] axi_wdata,
  output logic [3:0]      axi_wstrb,
  output logic            axi_wlast,
  input  logic            axi_bvalid,
  output logic            axi_bready,
  input  logic [1:0]      axi_bresp
);

  lsu_br_state_t r_state, w_next_state;

  // Latched request and captured response
  logic [XLEN-1:0] r_addr,  w_addr;
  logic [3:0]      r_strb,  w_strb;
  logic [XLEN-1:0] r_wdata, w_wdata;
  logic [XLEN-1:0] r_rdata, w_rdata;
  logic            r_abandon, w_abandon;
  logic            r_aw_done, w_aw_done;
  logic            r_w_done,  w_w_done;

  // Registered handshake outputs
  logic r_arvalid,    w_arvalid;
  logic r_rready,     w_rready;
  logic r_awvalid,    w_awvalid;
  logic r_wvalid,     w_wvalid;
  logic r_bready,     w_bready;
  logic r_lsu_rvalid, w_lsu_rvalid;
  logic r_lsu_wready, w_lsu_wready;
  logic r_bus_err,    w_bus_err;

  logic [3:0]      w_axi_wstrb;
  logic [XLEN-1:0] w_axi_wdata;

  // Upper strobe halves are always zero from the LSU and carry no information.
  logic w_unused;
  assign w_unused = ^{lsu_rstrb[7:4], lsu_wstrb[7:4]};

  ysyx_axi_lane_shift #(.XLEN(XLEN)) u_lane_shift (
    .i_sh   (r_addr[1:0]),
    .i_strb (r_strb),
    .i_data (r_wdata),
    .o_strb (w_axi_wstrb),
    .o_data (w_axi_wdata)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, next-output and request/response capture decisions.
  always_comb begin
    w_next_state = r_state;
    w_addr       = r_addr;
    w_strb       = r_strb;
    w_wdata      = r_wdata;
    w_rdata      = r_rdata;
    w_abandon    = r_abandon;
    w_aw_done    = r_aw_done;
    w_w_done     = r_w_done;
    w_arvalid    = 1'b0;
    w_rready     = 1'b0;
    w_awvalid    = 1'b0;
    w_wvalid     = 1'b0;
    w_bready     = 1'b0;
    w_lsu_rvalid = 1'b0;
    w_lsu_wready = 1'b0;
    w_bus_err    = 1'b0;
    case (r_state)
      IDLE: begin
        w_abandon = 1'b0;
        if ((lsu_awvalid && lsu_wvalid) && (WRITE_FIRST || !lsu_arvalid)) begin
          w_next_state = WR_AW;
          w_addr       = lsu_awaddr;
          w_strb       = lsu_wstrb[3:0];
          w_wdata      = lsu_wdata;
          w_aw_done    = 1'b0;
          w_w_done     = 1'b0;
          w_awvalid    = 1'b1;
          w_wvalid     = 1'b1;
        end else if (lsu_arvalid) begin
          w_next_state = RD_A;
          w_addr       = lsu_araddr;
          w_strb       = lsu_rstrb[3:0];
          w_arvalid    = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      RD_A: begin
        w_abandon = r_abandon | ~lsu_arvalid;
        if (axi_arready) begin
          w_next_state = RD_D;
          w_rready     = 1'b1;
        end else begin
          w_arvalid = 1'b1;
        end
      end
      RD_D: begin
        w_abandon = r_abandon | ~lsu_arvalid;
        if (axi_rvalid) begin
          // A flushed load still drains the AXI read but is not answered.
          w_next_state = RD_ACK;
          w_rdata      = axi_rdata;
          w_lsu_rvalid = ~w_abandon;
          w_bus_err    = ~w_abandon & (axi_rresp != AXI_RESP_OKAY);
        end else begin
          w_rready = 1'b1;
        end
      end
      RD_ACK: begin
        w_next_state = IDLE;
      end
      WR_AW: begin
        // Address and data channels complete independently, possibly together.
        w_aw_done = r_aw_done | axi_awready;
        w_w_done  = r_w_done  | axi_wready;
        if (w_aw_done && w_w_done) begin
          w_next_state = WR_B;
          w_bready     = 1'b1;
        end else begin
          w_awvalid = ~w_aw_done;
          w_wvalid  = ~w_w_done;
        end
      end
      WR_B: begin
        if (axi_bvalid) begin
          w_next_state = WR_ACK;
          w_lsu_wready = 1'b1;
          w_bus_err    = (axi_bresp != AXI_RESP_OKAY);
        end else begin
          w_bready = 1'b1;
        end
      end
      WR_ACK: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Request, response and handshake output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr       <= {XLEN{1'b0}};
      r_strb       <= 4'h0;
      r_wdata      <= {XLEN{1'b0}};
      r_rdata      <= {XLEN{1'b0}};
      r_abandon    <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_lsu_wready <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_addr       <= w_addr;
      r_strb       <= w_strb;
      r_wdata      <= w_wdata;
      r_rdata      <= w_rdata;
      r_abandon    <= w_abandon;
      r_aw_done    <= w_aw_done;
      r_w_done     <= w_w_done;
      r_arvalid    <= w_arvalid;
      r_rready     <= w_rready;
      r_awvalid    <= w_awvalid;
      r_wvalid     <= w_wvalid;
      r_bready     <= w_bready;
      r_lsu_rvalid <= w_lsu_rvalid;
      r_lsu_wready <= w_lsu_wready;
      r_bus_err    <= w_bus_err;
    end
  end

  assign lsu_rvalid  = r_lsu_rvalid;
  assign lsu_rdata   = r_rdata;
  assign lsu_wready  = r_lsu_wready;
  assign bus_err     = r_bus_err;

  assign axi_arvalid = r_arvalid;
  assign axi_araddr  = r_addr;
  assign axi_arsize  = strb2size(r_strb);
  assign axi_arlen   = 8'd0;
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_rready  = r_rready;

  assign axi_awvalid = r_awvalid;
  assign axi_awaddr  = r_addr;
  assign axi_awsize  = strb2size(r_strb);
  assign axi_awlen   = 8'd0;
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_wvalid  = r_wvalid;
  assign axi_wdata   = w_axi_wdata;
  assign axi_wstrb   = w_axi_wstrb;
  assign axi_wlast   = 1'b1;
  assign axi_bready  = r_bready;

endmodule

// File: tb/tb_ysyx_lsu_axi_bridge.sv
// Bench for ysyx_lsu_axi_bridge: plays both the LSU and an AXI slave with
// randomised ready/valid delays, and checks every handshake and answer pulse
// against a transaction-level model of the bridge.
module tb_ysyx_lsu_axi_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        lsu_arvalid;
  logic [31:0] lsu_araddr;
  logic [7:0]  lsu_rstrb;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_awvalid;
  logic [31:0] lsu_awaddr;
  logic [7:0]  lsu_wstrb;
  logic        lsu_wvalid;
  logic [31:0] lsu_wdata;
  logic        lsu_wready;
  logic        bus_err;
  logic        axi_arvalid, axi_arready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arsize;
  logic [7:0]  axi_arlen;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid, axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awsize;
  logic [7:0]  axi_awlen;
  logic [1:0]  axi_awburst;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;

  always #5 clock = ~clock;

  ysyx_lsu_axi_bridge #(.XLEN(32), .WRITE_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_rstrb(lsu_rstrb),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_wstrb(lsu_wstrb),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wready(lsu_wready),
    .bus_err(bus_err),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arsize(axi_arsize), .axi_arlen(axi_arlen), .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awsize(axi_awsize), .axi_awlen(axi_awlen), .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction configuration
  bit          t_rd, t_wr, t_ab, t_use_rdata0;
  logic [31:0] t_ra, t_ra2, t_wa, t_wd, t_rdata0;
  logic [3:0]  t_rs, t_rs2, t_ws;
  logic [1:0]  t_rresp0, t_bresp;
  int          t_ar_dly, t_r_dly, t_aw_dly, t_w_dly, t_b_dly;

  function automatic logic [2:0] exp_size(input logic [3:0] s);
    if (s == 4'h1) return 3'd0;
    else if (s == 4'h3) return 3'd1;
    else return 3'd2;
  endfunction

  function automatic logic [3:0] rand_strb();
    int v;
    v = $urandom_range(0, 2);
    if (v == 0) return 4'h1;
    else if (v == 1) return 4'h3;
    else return 4'hf;
  endfunction

  function automatic logic [1:0] rand_resp();
    int v;
    v = $urandom_range(0, 5);
    if (v == 4) return 2'b10;
    else if (v == 5) return 2'b11;
    else return 2'b00;
  endfunction

  task automatic set_defaults();
    t_rd = 1'b0; t_wr = 1'b0; t_ab = 1'b0; t_use_rdata0 = 1'b0;
    t_ra = 32'h0; t_ra2 = 32'h0; t_wa = 32'h0; t_wd = 32'h0; t_rdata0 = 32'h0;
    t_rs = 4'hf; t_rs2 = 4'hf; t_ws = 4'hf; t_rresp0 = 2'b00; t_bresp = 2'b00;
    t_ar_dly = 0; t_r_dly = 0; t_aw_dly = 0; t_w_dly = 0; t_b_dly = 0;
  endtask

  task automatic idle_inputs();
    lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_awready = 1'b0;
    axi_wready = 1'b0; axi_bvalid = 1'b0;
  endtask

  // Runs one LSU request set (read, write, both, or an abandoned read followed by
  // a fresh read) cycle by cycle. Entered and left on a falling edge.
  task automatic run_txn();
    bit rd_live, wr_live, drop_now, r_pend, b_pend, b_started, r_ab_pend, last_r_ab;
    bit ar_hold, aw_hold, w_hold;
    logic [31:0] cur_ra, r_data, last_rdata, ar_prev, aw_prev, w_prev_d, exp_wd;
    logic [3:0]  cur_rs, w_prev_s, exp_ws;
    logic [1:0]  r_resp, last_rresp, sh;
    int ar_cnt, aw_cnt, w_cnt, rp_cnt, wp_cnt;
    int ar_c, r_c, aw_c, w_c, b_c, last_r_cyc, last_b_cyc;
    rd_live = t_rd; wr_live = t_wr; cur_ra = t_ra; cur_rs = t_rs;
    drop_now = 1'b0; r_pend = 1'b0; b_pend = 1'b0; b_started = 1'b0;
    r_ab_pend = 1'b0; last_r_ab = 1'b0; ar_hold = 1'b0; aw_hold = 1'b0; w_hold = 1'b0;
    r_data = 32'h0; r_resp = 2'b00; last_rdata = 32'h0; last_rresp = 2'b00;
    ar_prev = 32'h0; aw_prev = 32'h0; w_prev_d = 32'h0; w_prev_s = 4'h0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; rp_cnt = 0; wp_cnt = 0;
    ar_c = t_ar_dly; aw_c = t_aw_dly; w_c = t_w_dly; r_c = 0; b_c = 0;
    last_r_cyc = -10; last_b_cyc = -10;
    sh = t_wa[1:0];
    exp_ws = t_ws << sh;
    exp_wd = t_wd << (8 * sh);
    for (int cyc = 0; cyc < 300; cyc++) begin
      // Answers from the bridge
      if (lsu_rvalid) begin
        chk("rd_pulse_live", rd_live, 1);
        chk("rd_pulse_not_abandoned", last_r_ab, 0);
        chk("rdata", lsu_rdata, last_rdata);
        chk("rd_bus_err", bus_err, last_rresp != 2'b00);
        chk("rd_latency", cyc, last_r_cyc + 1);
        rd_live = 1'b0; rp_cnt++;
      end
      if (lsu_wready) begin
        chk("wr_pulse_live", wr_live, 1);
        chk("wr_bus_err", bus_err, t_bresp != 2'b00);
        chk("wr_latency", cyc, last_b_cyc + 1);
        wr_live = 1'b0; wp_cnt++;
      end
      chk("bus_err_alone", bus_err && !lsu_rvalid && !lsu_wready, 0);
      // Valid must hold with a stable payload until accepted
      if (ar_hold) begin
        chk("ar_hold_valid", axi_arvalid, 1);
        chk("ar_hold_addr", axi_araddr, ar_prev);
      end
      if (aw_hold) begin
        chk("aw_hold_valid", axi_awvalid, 1);
        chk("aw_hold_addr", axi_awaddr, aw_prev);
      end
      if (w_hold) begin
        chk("w_hold_valid", axi_wvalid, 1);
        chk("w_hold_payload", {axi_wstrb, axi_wdata}, {w_prev_s, w_prev_d});
      end
      if (!rd_live && !wr_live) break;
      // LSU side
      if (drop_now) begin
        lsu_arvalid = 1'b0;
        drop_now = 1'b0;
        cur_ra = t_ra2; cur_rs = t_rs2;
      end else begin
        lsu_arvalid = rd_live;
      end
      lsu_araddr = cur_ra; lsu_rstrb = {4'h0, cur_rs};
      lsu_awvalid = wr_live; lsu_wvalid = wr_live;
      lsu_awaddr = t_wa; lsu_wstrb = {4'h0, t_ws}; lsu_wdata = t_wd;
      // Slave side
      axi_arready = 1'b0;
      if (axi_arvalid) begin
        if (ar_c == 0) axi_arready = 1'b1; else ar_c--;
      end
      axi_awready = 1'b0;
      if (axi_awvalid) begin
        if (aw_c == 0) axi_awready = 1'b1; else aw_c--;
      end
      axi_wready = 1'b0;
      if (axi_wvalid) begin
        if (w_c == 0) axi_wready = 1'b1; else w_c--;
      end
      axi_rvalid = 1'b0;
      if (r_pend) begin
        if (r_c == 0) axi_rvalid = 1'b1; else r_c--;
      end
      axi_rdata = r_data; axi_rresp = r_resp;
      axi_bvalid = 1'b0;
      if (b_pend) begin
        if (b_c == 0) axi_bvalid = 1'b1; else b_c--;
      end
      axi_bresp = t_bresp;
      // Handshakes that the coming rising edge completes
      if (axi_arvalid && axi_arready) begin
        chk("ar_addr", axi_araddr, cur_ra);
        chk("ar_size", axi_arsize, exp_size(cur_rs));
        chk("ar_len_burst", {axi_arlen, axi_arburst}, {8'd0, 2'b01});
        chk("ar_while_busy", r_pend, 0);
        chk("ar_before_write_done", wr_live, 0);
        r_pend = 1'b1; r_c = t_r_dly;
        if (ar_cnt == 0 && t_use_rdata0) begin
          r_data = t_rdata0; r_resp = t_rresp0;
        end else begin
          r_data = $urandom; r_resp = rand_resp();
        end
        r_ab_pend = (ar_cnt == 0) && t_ab;
        if (r_ab_pend) drop_now = 1'b1;
        ar_cnt++;
      end
      if (axi_rvalid && axi_rready) begin
        last_rdata = r_data; last_rresp = r_resp; last_r_ab = r_ab_pend;
        last_r_cyc = cyc; r_pend = 1'b0;
      end
      if (axi_awvalid && axi_awready) begin
        chk("aw_addr", axi_awaddr, t_wa);
        chk("aw_size", axi_awsize, exp_size(t_ws));
        chk("aw_len_burst", {axi_awlen, axi_awburst}, {8'd0, 2'b01});
        aw_cnt++;
      end
      if (axi_wvalid && axi_wready) begin
        chk("w_strb", axi_wstrb, exp_ws);
        chk("w_data", axi_wdata, exp_wd);
        chk("w_last", axi_wlast, 1);
        w_cnt++;
      end
      if (axi_bvalid && axi_bready) begin
        last_b_cyc = cyc; b_pend = 1'b0;
      end
      if (!b_started && aw_cnt > 0 && w_cnt > 0) begin
        b_started = 1'b1; b_pend = 1'b1; b_c = t_b_dly;
      end
      ar_hold = axi_arvalid && !axi_arready; ar_prev = axi_araddr;
      aw_hold = axi_awvalid && !axi_awready; aw_prev = axi_awaddr;
      w_hold = axi_wvalid && !axi_wready; w_prev_d = axi_wdata; w_prev_s = axi_wstrb;
      @(posedge clock);
      @(negedge clock);
    end
    chk("txn_complete", rd_live || wr_live, 0);
    chk("rd_pulse_count", rp_cnt, t_rd ? 1 : 0);
    chk("wr_pulse_count", wp_cnt, t_wr ? 1 : 0);
    chk("ar_count", ar_cnt, t_rd ? (t_ab ? 2 : 1) : 0);
    chk("aw_w_count", {aw_cnt[7:0], w_cnt[7:0]}, t_wr ? 16'h0101 : 16'h0000);
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("idle_no_pulse", {lsu_rvalid, lsu_wready, bus_err}, 3'b000);
      chk("idle_axi_quiet", {axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready}, 5'b0);
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    idle_inputs();
    lsu_araddr = 32'h0; lsu_rstrb = 8'h0; lsu_awaddr = 32'h0; lsu_wstrb = 8'h0; lsu_wdata = 32'h0;
    axi_rdata = 32'h0; axi_rresp = 2'b00; axi_bresp = 2'b00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {lsu_rvalid, lsu_wready, bus_err, axi_arvalid, axi_awvalid,
                          axi_wvalid, axi_rready, axi_bready}, 8'h00);
    reset = 1'b0;

    // LW with delayed arready
    set_defaults();
    t_rd = 1'b1; t_ra = 32'h8000_0004; t_rs = 4'hf; t_use_rdata0 = 1'b1;
    t_rdata0 = 32'hdead_beef; t_ar_dly = 2;
    run_txn();

    // SB to the top byte lane
    set_defaults();
    t_wr = 1'b1; t_wa = 32'h1000_0003; t_wd = 32'h0000_0041; t_ws = 4'h1; t_b_dly = 2;
    run_txn();

    // Simultaneous load and store: store goes first
    set_defaults();
    t_rd = 1'b1; t_ra = 32'h8000_0100; t_rs = 4'h3;
    t_wr = 1'b1; t_wa = 32'h8000_0200; t_wd = 32'h1234_5678; t_ws = 4'hf;
    t_ar_dly = 1; t_r_dly = 1; t_b_dly = 1;
    run_txn();

    // Load flushed in RD_D, followed by a fresh LH
    set_defaults();
    t_rd = 1'b1; t_ab = 1'b1; t_ra = 32'h8000_0008; t_rs = 4'hf;
    t_ra2 = 32'h8000_0010; t_rs2 = 4'h3; t_r_dly = 2;
    run_txn();

    // awready first, wready three cycles later, SLVERR response
    set_defaults();
    t_wr = 1'b1; t_wa = 32'h2000_0002; t_wd = 32'h0000_beef; t_ws = 4'h3;
    t_aw_dly = 0; t_w_dly = 3; t_bresp = 2'b10; t_b_dly = 1;
    run_txn();

    // Reset while waiting for the write response
    lsu_awaddr = 32'h3000_0000; lsu_wstrb = 8'h0f; lsu_wdata = 32'hcafe_f00d;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1; axi_awready = 1'b1; axi_wready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (axi_bready) seen = 1'b1;
    end
    chk("reached_wr_b", seen, 1);
    reset = 1'b1;
    idle_inputs();
    @(posedge clock);
    @(negedge clock);
    chk("rst_mid_axi", {axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready}, 5'b0);
    chk("rst_mid_lsu", {lsu_rvalid, lsu_wready, bus_err}, 3'b000);
    reset = 1'b0;
    axi_bvalid = 1'b1; axi_bresp = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("rst_no_late_wready", {lsu_wready, axi_bready}, 2'b00);
    end
    axi_bvalid = 1'b0;
    set_defaults();
    t_rd = 1'b1; t_ra = 32'h8000_0020; t_rs = 4'h1;
    run_txn();

    // Randomised mix
    for (int n = 0; n < 40; n++) begin
      int kind;
      set_defaults();
      kind = $urandom_range(0, 3);
      t_rd = (kind != 1);
      t_wr = (kind == 1) || (kind == 2);
      t_ab = (kind == 3);
      t_ra = $urandom; t_rs = rand_strb();
      t_ra2 = $urandom; t_rs2 = rand_strb();
      t_wa = $urandom; t_ws = rand_strb(); t_wd = $urandom;
      t_bresp = rand_resp();
      t_ar_dly = $urandom_range(0, 3); t_r_dly = $urandom_range(0, 3);
      t_aw_dly = $urandom_range(0, 3); t_w_dly = $urandom_range(0, 3);
      t_b_dly = $urandom_range(0, 3);
      run_txn();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
